// File: rtl/apb_pkg.sv
// Shared APB-side types and helpers for the memory slave and the master side.
//   apb_state_e : slave FSM state encoding
//   STRB_W      : wait-counter width (covers 0..15 wait cycles)
//   f_addr_err  : out-of-range / misaligned byte-address detection
//   f_max       : constant-friendly maximum of two values
package apb_pkg;

  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDCAP  = 2'd2
  } apb_state_e;

  // Evaluated at 64 bits so any ADDR_WIDTH up to 64 fits without overflow of base+size.
  function automatic logic f_addr_err(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] words,
                                      input logic [63:0] bytes);
    logic [63:0] lim;
    logic        misal;
    lim   = base + (words * bytes);
    // Byte-wide data has no alignment constraint.
    misal = (bytes > 64'd1) && ((addr & (bytes - 64'd1)) != 64'd0);
    return (addr < base) || (addr >= lim) || misal;
  endfunction

  function automatic int unsigned f_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter used to time APB access phases.
//   clk, rst_n    : clock, async active-low reset
//   i_load        : load i_load_val (has priority over i_dec)
//   i_dec         : decrement by one, saturating at zero
//   i_load_val    : value to load
//   o_zero        : registered flag, counter is zero
//   o_zero_nxt_c  : combinational flag, counter will be zero after this edge
module apb_wait_ctr
  import apb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_dec,
  input  logic [STRB_W-1:0] i_load_val,
  output logic              o_zero,
  output logic              o_zero_nxt_c
);

  logic [STRB_W-1:0] r_cnt;
  logic [STRB_W-1:0] w_cnt_nxt;
  logic              r_zero;

  // Next count: load wins, decrement saturates at zero.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - STRB_W'(1);
    end
  end

  assign o_zero_nxt_c = (w_cnt_nxt == '0);
  assign o_zero       = r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_zero <= 1'b1;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_zero <= (w_cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/apb_mem_slave_ws.sv
// APB slave terminating transfers into a synchronous single-port memory,
// with programmable wait states, memory read latency and slverr reporting.
//   clk, rst_n          : clock, async active-low reset
//   i_sel/i_enable      : APB select / access phase
//   i_write, i_strobe   : direction and write byte lanes
//   i_addr, i_wdata     : byte address, write data
//   o_ready, o_slverr   : transfer complete, error response (only with ready)
//   o_rdata             : captured read data
//   o_mem_wr/o_mem_rd   : one-cycle memory strobes
//   o_mem_be            : byte enables
//   o_mem_address       : word address relative to BASE_ADDR
//   o_mem_data_in       : memory write data
//   i_mem_data_out      : memory read data, valid RD_LAT cycles after o_mem_rd
module apb_mem_slave_ws
  import apb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_WORDS   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0,
  parameter int unsigned           RD_LAT      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_sel,
  input  logic                         i_enable,
  input  logic                         i_write,
  input  logic [DATA_WIDTH/8-1:0]      i_strobe,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  output logic                         o_ready,
  output logic                         o_slverr,
  output logic [DATA_WIDTH-1:0]        o_rdata,
  output logic                         o_mem_wr,
  output logic                         o_mem_rd,
  output logic [DATA_WIDTH/8-1:0]      o_mem_be,
  output logic [$clog2(MEM_WORDS)-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0]        o_mem_data_in,
  input  logic [DATA_WIDTH-1:0]        i_mem_data_out
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned AW    = $clog2(MEM_WORDS);
  localparam int unsigned CAP_W = 3;
  // Reads wait at least until the captured data has landed in o_rdata.
  localparam int unsigned RD_N  = f_max(WAIT_STATES, RD_LAT + 1);

  apb_state_e          r_state;
  apb_state_e          w_state_nxt;
  logic                w_start;
  logic                w_dec;
  logic                w_err;
  logic                w_err_nxt;
  logic                w_zero;
  logic                w_zero_nxt;
  logic                w_ready_nxt;
  logic [STRB_W-1:0]   w_load_val;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [AW-1:0]       w_word;

  logic                r_err;
  logic                r_ready;
  logic                r_slverr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                r_mem_wr;
  logic                r_mem_rd;
  logic [BYTES-1:0]    r_mem_be;
  logic [AW-1:0]       r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data_in;
  logic                r_cap_pend;
  logic [CAP_W-1:0]    r_cap_cnt;

  // Setup-cycle decode: error flag, word address and access length.
  assign w_err      = f_addr_err(64'(i_addr), 64'(BASE_ADDR), 64'(MEM_WORDS), 64'(BYTES));
  assign w_off      = i_addr - BASE_ADDR;
  assign w_word     = AW'(w_off >> LSB);
  assign w_load_val = w_err ? '0 : (i_write ? STRB_W'(WAIT_STATES) : STRB_W'(RD_N));

  apb_wait_ctr u_wait_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_start),
    .i_dec        (w_dec),
    .i_load_val   (w_load_val),
    .o_zero       (w_zero),
    .o_zero_nxt_c (w_zero_nxt)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; setup with enable already high is a protocol violation and ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_sel && !i_enable) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!i_sel || w_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Ready/slverr registered from next state so they line up with the zero count.
  assign w_ready_nxt = (w_state_nxt == ST_ACCESS) && w_zero_nxt;
  assign w_err_nxt   = w_start ? w_err : r_err;

  // Datapath: memory request, error latch and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err         <= 1'b0;
      r_ready       <= 1'b0;
      r_slverr      <= 1'b0;
      r_rdata       <= '0;
      r_mem_wr      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_be      <= '0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_cap_pend    <= 1'b0;
      r_cap_cnt     <= '0;
    end else begin
      r_ready  <= w_ready_nxt;
      r_slverr <= w_ready_nxt && w_err_nxt;
      r_mem_wr <= 1'b0;
      r_mem_rd <= 1'b0;
      if (w_start) begin
        r_err      <= w_err;
        r_cap_pend <= !i_write && !w_err;
        r_cap_cnt  <= CAP_W'(RD_LAT);
        if (!w_err) begin
          r_mem_wr      <= i_write;
          r_mem_rd      <= !i_write;
          r_mem_address <= w_word;
          r_mem_be      <= i_write ? i_strobe : '1;
          r_mem_data_in <= i_wdata;
        end else if (!i_write) begin
          r_rdata <= '0;
        end
      end else if ((r_state == ST_ACCESS) && r_cap_pend) begin
        // Count RD_LAT access cycles after the strobe, then sample memory.
        if (r_cap_cnt == '0) begin
          r_rdata    <= i_mem_data_out;
          r_cap_pend <= 1'b0;
        end else begin
          r_cap_cnt <= r_cap_cnt - CAP_W'(1);
        end
      end
    end
  end

  assign o_ready       = r_ready;
  assign o_slverr      = r_slverr;
  assign o_rdata       = r_rdata;
  assign o_mem_wr      = r_mem_wr;
  assign o_mem_rd      = r_mem_rd;
  assign o_mem_be      = r_mem_be;
  assign o_mem_address = r_mem_address;
  assign o_mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_apb_mem_slave_ws.sv
// Directed bench: instance 0 has no wait states, instance 1 has three; both
// use BASE_ADDR=0x1000, 256 x 32-bit words and a one-cycle-latency memory model.
module tb_apb_mem_slave_ws;

  logic clk = 1'b0;
  logic rst_n;

  logic        sel    [2];
  logic        en     [2];
  logic        wr     [2];
  logic [3:0]  strb   [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        ready  [2];
  logic        slverr [2];
  logic [31:0] rdata  [2];
  logic        mem_wr [2];
  logic        mem_rd [2];
  logic [3:0]  mem_be [2];
  logic [7:0]  mem_addr [2];
  logic [31:0] mem_din  [2];
  logic [31:0] mem_dout [2];
  logic [31:0] mem [2][256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    apb_mem_slave_ws #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .MEM_WORDS   (256),
      .BASE_ADDR   (32'h1000),
      .WAIT_STATES ((g == 0) ? 0 : 3),
      .RD_LAT      (1)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_sel          (sel[g]),
      .i_enable       (en[g]),
      .i_write        (wr[g]),
      .i_strobe       (strb[g]),
      .i_addr         (addr[g]),
      .i_wdata        (wdata[g]),
      .o_ready        (ready[g]),
      .o_slverr       (slverr[g]),
      .o_rdata        (rdata[g]),
      .o_mem_wr       (mem_wr[g]),
      .o_mem_rd       (mem_rd[g]),
      .o_mem_be       (mem_be[g]),
      .o_mem_address  (mem_addr[g]),
      .o_mem_data_in  (mem_din[g]),
      .i_mem_data_out (mem_dout[g])
    );
  end

  // Memory model: byte-lane writes, read data one cycle after mem_rd.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mem[i][1]   <= 32'h1122_3344;
        mem[i][4]   <= 32'hDEAD_BEEF;
        mem_dout[i] <= 32'h0;
      end else begin
        if (mem_wr[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_be[i][b]) mem[i][mem_addr[i]][8*b +: 8] <= mem_din[i][8*b +: 8];
          end
        end
        if (mem_rd[i]) mem_dout[i] <= mem[i][mem_addr[i]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // One transfer starting at the beginning of its setup cycle; returns just
  // after the edge following the ready cycle, with sel/enable dropped.
  task automatic xfer(input int i, input bit w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input int n,
                      input bit err, input logic [7:0] wa, input logic [31:0] rd_exp);
    sel[i] = 1'b1; en[i] = 1'b0; wr[i] = w; addr[i] = a; wdata[i] = wd; strb[i] = st;
    @(posedge clk); #1;
    en[i] = 1'b1;
    @(negedge clk);
    check("t1_mem_wr", 64'(mem_wr[i]), 64'(!err && w));
    check("t1_mem_rd", 64'(mem_rd[i]), 64'(!err && !w));
    if (!err) begin
      check("t1_mem_addr", 64'(mem_addr[i]), 64'(wa));
      check("t1_mem_be", 64'(mem_be[i]), 64'(w ? st : 4'hF));
      if (w) check("t1_mem_din", 64'(mem_din[i]), 64'(wd));
    end
    for (int k = 0; k <= n; k++) begin
      if (k > 0) @(negedge clk);
      check("ready", 64'(ready[i]), 64'(k == n));
      if (k == 1) check("strobe_one_cycle", 64'({mem_wr[i], mem_rd[i]}), 64'(0));
    end
    check("slverr", 64'(slverr[i]), 64'(err));
    if (!w) check("rdata", 64'(rdata[i]), 64'(rd_exp));
    @(posedge clk); #1;
    sel[i] = 1'b0; en[i] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 1'b0; en[i] = 1'b0; wr[i] = 1'b0; strb[i] = 4'h0;
      addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready[0]), 64'(0));
    check("rst_slverr", 64'(slverr[0]), 64'(0));
    check("rst_rdata", 64'(rdata[0]), 64'(0));
    check("rst_mem_wr", 64'(mem_wr[0]), 64'(0));
    check("rst_mem_rd", 64'(mem_rd[0]), 64'(0));
    check("rst_mem_be", 64'(mem_be[0]), 64'(0));
    check("rst_mem_addr", 64'(mem_addr[0]), 64'(0));
    check("rst_mem_din", 64'(mem_din[0]), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero wait states: reads take N=2 (ready in T3), writes complete in T1.
    xfer(0, 1'b0, 32'h1010, 32'h0, 4'h0, 2, 1'b0, 8'd4, 32'hDEAD_BEEF);
    xfer(0, 1'b1, 32'h1010, 32'hA5A5_1234, 4'b0011, 0, 1'b0, 8'd4, 32'h0);
    xfer(0, 1'b0, 32'h1010, 32'h0, 4'h0, 2, 1'b0, 8'd4, 32'hDEAD_1234);
    // Errors: above range, misaligned, below base.
    xfer(0, 1'b1, 32'h1400, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, 8'd0, 32'h0);
    xfer(0, 1'b0, 32'h1002, 32'h0, 4'h0, 0, 1'b1, 8'd0, 32'h0);
    xfer(0, 1'b0, 32'h0FFC, 32'h0, 4'h0, 0, 1'b1, 8'd0, 32'h0);
    // Back-to-back write then read, merged per strobe.
    xfer(0, 1'b1, 32'h1004, 32'hCAFE_F00D, 4'b1100, 0, 1'b0, 8'd1, 32'h0);
    xfer(0, 1'b0, 32'h1004, 32'h0, 4'h0, 2, 1'b0, 8'd1, 32'hCAFE_3344);

    // Setup with enable already high must be ignored.
    sel[0] = 1'b1; en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h1000;
    @(posedge clk); #1;
    sel[0] = 1'b0; en[0] = 1'b0;
    @(negedge clk);
    check("viol_strobe", 64'({mem_wr[0], mem_rd[0]}), 64'(0));
    check("viol_ready", 64'(ready[0]), 64'(0));
    @(posedge clk); #1;

    // Three wait states: both directions complete in T4.
    xfer(1, 1'b1, 32'h1008, 32'h1234_5678, 4'hF, 3, 1'b0, 8'd2, 32'h0);
    xfer(1, 1'b0, 32'h1008, 32'h0, 4'h0, 3, 1'b0, 8'd2, 32'h1234_5678);

    // Abort: sel dropped in T2; the T1 write strobe still reaches memory.
    sel[1] = 1'b1; en[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h100C;
    wdata[1] = 32'h0BAD_CAFE; strb[1] = 4'hF;
    @(posedge clk); #1;
    en[1] = 1'b1;
    @(negedge clk);
    check("abort_t1_wr", 64'(mem_wr[1]), 64'(1));
    check("abort_t1_ready", 64'(ready[1]), 64'(0));
    @(posedge clk); #1;
    sel[1] = 1'b0; en[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_ready", 64'(ready[1]), 64'(0));
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h100C, 32'h0, 4'h0, 3, 1'b0, 8'd3, 32'h0BAD_CAFE);

    // Reset pulsed during a read: outputs clear immediately, no late strobe.
    sel[1] = 1'b1; en[1] = 1'b0; wr[1] = 1'b0; addr[1] = 32'h1008;
    @(posedge clk); #1;
    en[1] = 1'b1;
    @(negedge clk);
    check("rst_mid_t1_rd", 64'(mem_rd[1]), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready[1]), 64'(0));
    check("rst_mid_mem_rd", 64'(mem_rd[1]), 64'(0));
    check("rst_mid_rdata", 64'(rdata[1]), 64'(0));
    check("rst_mid_mem_addr", 64'(mem_addr[1]), 64'(0));
    check("rst_mid_mem_be", 64'(mem_be[1]), 64'(0));
    sel[1] = 1'b0; en[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("post_rst_idle", 64'({ready[1], mem_rd[1], mem_wr[1]}), 64'(0));
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h1008, 32'h0, 4'h0, 3, 1'b0, 8'd2, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
